nios_gpio_edge_pio: RTL and testbench



---
 rtl/nios_gpio_pkg.sv | 30 +++
 rtl/nios_gpio_sync.sv | 33 +++
 rtl/nios_gpio_edge_pio.sv | 132 +++++++++++++
 tb/tb_nios_gpio_edge_pio.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_gpio_pkg.sv
// Shared definitions for the Nios GPIO edge-capture PIO.
//   - register word offsets on the Avalon-MM slave
//   - edge_type_e: which pin transition sets an EDGECAP bit
//   - edge_hit(): per-bit edge qualifier for a given edge type
package nios_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    function automatic logic edge_hit(logic cur, logic prev, edge_type_e et);
        logic hit;
        case (et)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            default:   hit = cur ^ prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/nios_gpio_sync.sv
// Multi-stage synchroniser for asynchronous pin inputs.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset, clears every stage
//   d_i      : WIDTH asynchronous inputs
//   q_o      : WIDTH synchronised outputs (STAGES clocks of latency)
module nios_gpio_sync #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/nios_gpio_edge_pio.sv
// Avalon-MM general-purpose I/O with direction control, atomic set/clear,
// synchronised inputs, per-bit edge capture and a maskable level irq.
//   clk, reset_n         : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata   : Avalon-MM slave write side
//   readdata             : combinational read data (upper bits zero)
//   in_port              : asynchronous pins
//   out_port, oe         : output data and per-bit output enable
//   irq                  : |(EDGECAP & IRQMASK), active high
module nios_gpio_edge_pio
    import nios_gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam edge_type_e ET       = edge_type_e'(EDGE_TYPE);
    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q,  cap_d;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       warm_q, warm_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_val;
    logic             wr;

    nios_gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (sync_in)
    );

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // Edges are ignored until the synchroniser and prev register have been
    // filled from the real pins, so a pin held high across reset release
    // does not look like a rising edge.
    always_comb begin
        edges = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            edges[i] = edge_hit(sync_in[i], prev_q[i], ET);
        end
        edges  = edges & ~dir_q & {WIDTH{warm_q == WARM_MAX}};
        warm_d = (warm_q == WARM_MAX) ? warm_q : warm_q + 3'd1;
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr) begin
            case (address)
                ADDR_DATA:    out_d  = wd;
                ADDR_DIR:     dir_d  = wd;
                ADDR_IRQMASK: mask_d = wd;
                ADDR_EDGECAP: cap_d  = cap_q & ~wd;
                ADDR_OUTSET:  out_d  = out_q | wd;
                ADDR_OUTCLR:  out_d  = out_q & ~wd;
                default:      ;
            endcase
        end
        // A new edge overrides a same-cycle write-1-to-clear.
        cap_d = cap_d | edges;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            prev_q <= sync_in;
            warm_q <= warm_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = (sync_in & ~dir_q) | (out_q & dir_q);
            ADDR_DIR:     rd_val = dir_q;
            ADDR_IRQMASK: rd_val = mask_q;
            ADDR_EDGECAP: rd_val = cap_q;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = out_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_gpio_edge_pio.sv
module tb_nios_gpio_edge_pio;
  import nios_gpio_pkg::*;

  localparam int unsigned W = 10;

  typedef enum int { K_RD, K_OUT, K_OE, K_IRQ } kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic [W-1:0] oe;
  logic         irq;

  sb_entry_t sb[$];
  int        checks   = 0;
  int        failures = 0;

  nios_gpio_edge_pio #(
    .WIDTH       (W),
    .RESET_VALUE (10'h2A5),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t   e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = readdata;
        K_OUT:   act = 32'(out_port);
        K_OE:    act = 32'(oe);
        default: act = 32'(irq);
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [31:0] v, input string n);
    sb_entry_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] v, input string n);
    address = a;
    expect_val(K_RD, v, n);
    tick(1);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = ADDR_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 10'h3FF;
    #1;

    expect_val(K_OUT, 32'h2A5, "rst_out");
    expect_val(K_OE,  32'h0,   "rst_oe");
    expect_val(K_IRQ, 32'h0,   "rst_irq");
    rd_check(ADDR_DATA, 32'h0, "rst_data");
    tick(2);

    reset_n = 1'b1;
    tick(8);
    rd_check(ADDR_EDGECAP, 32'h0,   "warm_cap");
    rd_check(ADDR_DATA,    32'h3FF, "warm_data");

    in_port = 10'h145;
    tick(4);
    bus_write(ADDR_DIR, 32'h00F);
    expect_val(K_OE, 32'h00F, "dir_oe");
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    expect_val(K_OUT, 32'h3FF, "data_out");
    bus_write(ADDR_OUTCLR, 32'h005);
    expect_val(K_OUT, 32'h3FA, "outclr");
    bus_write(ADDR_OUTSET, 32'h100);
    expect_val(K_OUT, 32'h3FA, "outset");
    rd_check(ADDR_DATA,    32'h14A, "rd_data_mix");
    rd_check(ADDR_DIR,     32'h00F, "rd_dir");
    rd_check(ADDR_OUTSET,  32'h0,   "rd_outset");
    rd_check(3'd6,         32'h0,   "rd_off6");
    rd_check(ADDR_EDGECAP, 32'h0,   "fall_no_cap");

    bus_write(ADDR_IRQMASK, 32'h010);
    expect_val(K_IRQ, 32'h0, "mask_irq0");
    in_port = 10'h157;
    tick(1);
    expect_val(K_IRQ, 32'h0, "lat_e1");
    tick(1);
    expect_val(K_IRQ, 32'h0, "lat_e2");
    tick(1);
    expect_val(K_IRQ, 32'h1, "lat_e3");
    rd_check(ADDR_EDGECAP, 32'h010, "cap_bit4");
    bus_write(ADDR_IRQMASK, 32'h0);
    expect_val(K_IRQ, 32'h0, "unmask_irq");
    bus_write(ADDR_IRQMASK, 32'h010);
    expect_val(K_IRQ, 32'h1, "remask_irq");

    in_port = 10'h147;
    tick(4);
    expect_val(K_IRQ, 32'h1, "fall_irq");
    rd_check(ADDR_EDGECAP, 32'h010, "fall_cap");

    in_port = 10'h157;
    tick(2);
    bus_write(ADDR_EDGECAP, 32'h010);
    expect_val(K_IRQ, 32'h1, "race_irq");
    rd_check(ADDR_EDGECAP, 32'h010, "race_cap");
    bus_write(ADDR_DIR, 32'h01F);
    rd_check(ADDR_EDGECAP, 32'h010, "dir_keeps_cap");
    bus_write(ADDR_EDGECAP, 32'h010);
    expect_val(K_IRQ, 32'h0, "clr_irq");
    rd_check(ADDR_EDGECAP, 32'h0, "clr_cap");

    in_port = 10'h117;
    tick(4);
    bus_write(ADDR_IRQMASK, 32'h0C0);
    in_port = 10'h1D7;
    tick(4);
    expect_val(K_IRQ, 32'h1,   "pre_rst_irq");
    expect_val(K_OUT, 32'h3FA, "pre_rst_out");
    rd_check(ADDR_EDGECAP, 32'h0C0, "pre_rst_cap");
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL async_irq_now: got %b expected 0", irq);
    end
    checks++;
    if (out_port !== 10'h2A5) begin
      failures++;
      $display("FAIL async_out_now: got %h expected 2a5", out_port);
    end
    address = ADDR_EDGECAP;
    expect_val(K_IRQ, 32'h0,   "async_irq");
    expect_val(K_OUT, 32'h2A5, "async_out");
    expect_val(K_OE,  32'h0,   "async_oe");
    expect_val(K_RD,  32'h0,   "async_cap");
    tick(1);
    rd_check(ADDR_IRQMASK, 32'h0, "rst_mask");
    rd_check(ADDR_DIR,     32'h0, "rst_dir");

    reset_n = 1'b1;
    tick(8);
    rd_check(ADDR_EDGECAP, 32'h0,   "warm2_cap");
    rd_check(ADDR_DATA,    32'h1D7, "warm2_data");

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
